// File: rtl/inst_fetch_buffer.sv
// rtl/inst_fetch_buffer.sv - N-wide in-order fetch queue feeding the decoder
// Circular buffer with N enqueue/dequeue lanes, squash flush and WFI halt latch.
module inst_fetch_buffer #(
  parameter int N = 4,
  parameter int DEPTH = 16,
  parameter logic [31:0] HALT_INST = 32'h10500073
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         squash,
  input  logic [$clog2(N+1)-1:0]       in_count,
  input  logic [N*32-1:0]              in_pc,
  input  logic [N*32-1:0]              in_npc,
  input  logic [N*32-1:0]              in_inst,
  output logic [$clog2(N+1)-1:0]       in_accepted,
  output logic [N-1:0]                 out_valid,
  output logic [N*32-1:0]              out_pc,
  output logic [N*32-1:0]              out_npc,
  output logic [N*32-1:0]              out_inst,
  input  logic [$clog2(N+1)-1:0]       dispatch_count,
  output logic [$clog2(DEPTH+1)-1:0]   free_slots,
  output logic                         halted,
  output logic                         empty,
  output logic                         full
);

  localparam int CW = $clog2(N+1);
  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+1);

  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_npc  [DEPTH];
  logic [31:0]   mem_inst [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [FW-1:0] count;

  int   acc;
  int   lim;
  int   space;
  int   avail;
  int   eff;
  logic halt_hit;
  logic stop;

  // Acceptance stops at the first halt lane; only start-of-cycle space counts.
  always_comb begin
    acc      = 0;
    halt_hit = 1'b0;
    stop     = 1'b0;
    lim      = (int'(in_count) > N) ? N : int'(in_count);
    space    = DEPTH - int'(count);
    if (lim > space) lim = space;
    if (!reset && !squash && !halted) begin
      for (int i = 0; i < N; i++) begin
        if (!stop && i < lim) begin
          acc = i + 1;
          if (in_inst[i*32 +: 32] == HALT_INST) begin
            halt_hit = 1'b1;
            stop     = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    avail = (int'(count) > N) ? N : int'(count);
    eff   = (int'(dispatch_count) > avail) ? avail : int'(dispatch_count);
  end

  assign in_accepted = CW'(acc);
  assign free_slots  = FW'(DEPTH) - count;
  assign empty       = (count == '0);
  assign full        = (count == FW'(DEPTH));

  always_comb begin
    out_valid = '0;
    out_pc    = '0;
    out_npc   = '0;
    out_inst  = '0;
    for (int j = 0; j < N; j++) begin
      out_valid[j]       = (j < int'(count));
      out_pc[j*32 +: 32]   = mem_pc[head + PW'(j)];
      out_npc[j*32 +: 32]  = mem_npc[head + PW'(j)];
      out_inst[j*32 +: 32] = mem_inst[head + PW'(j)];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      halted <= 1'b0;
    end else if (squash) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      halted <= 1'b0;
    end else begin
      head  <= head + PW'(eff);
      tail  <= tail + PW'(acc);
      count <= count + FW'(acc) - FW'(eff);
      if (halt_hit) halted <= 1'b1;
    end
  end

  // Storage needs no reset; acc is already zero under reset or squash.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (i < acc) begin
        mem_pc[tail + PW'(i)]   <= in_pc[i*32 +: 32];
        mem_npc[tail + PW'(i)]  <= in_npc[i*32 +: 32];
        mem_inst[tail + PW'(i)] <= in_inst[i*32 +: 32];
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb/tb_inst_fetch_buffer.sv - directed self-checking bench for inst_fetch_buffer
module tb_inst_fetch_buffer;

  localparam int N = 4;
  localparam int DEPTH = 16;
  localparam logic [31:0] HALT = 32'h10500073;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic            clock = 1'b0;
  logic            reset;
  logic            squash;
  logic [2:0]      in_count;
  logic [N*32-1:0] in_pc;
  logic [N*32-1:0] in_npc;
  logic [N*32-1:0] in_inst;
  logic [2:0]      in_accepted;
  logic [N-1:0]    out_valid;
  logic [N*32-1:0] out_pc;
  logic [N*32-1:0] out_npc;
  logic [N*32-1:0] out_inst;
  logic [2:0]      dispatch_count;
  logic [4:0]      free_slots;
  logic            halted;
  logic            empty;
  logic            full;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  inst_fetch_buffer #(.N(N), .DEPTH(DEPTH), .HALT_INST(HALT)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .in_count(in_count), .in_pc(in_pc), .in_npc(in_npc), .in_inst(in_inst),
    .in_accepted(in_accepted), .out_valid(out_valid), .out_pc(out_pc),
    .out_npc(out_npc), .out_inst(out_inst), .dispatch_count(dispatch_count),
    .free_slots(free_slots), .halted(halted), .empty(empty), .full(full)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Lanes carry pc = base + 4*i; halt_lane < 0 means no halt instruction.
  task automatic set_lanes(input int n, input logic [31:0] base, input int halt_lane);
    in_count = 3'(n);
    for (int i = 0; i < N; i++) begin
      in_pc[i*32 +: 32]   = base + 32'(4 * i);
      in_npc[i*32 +: 32]  = base + 32'(4 * i + 4);
      in_inst[i*32 +: 32] = (i == halt_lane) ? HALT : NOP;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'h0);
    check_eq({tag, "_free"}, 32'(free_slots), 32'd16);
    check_eq({tag, "_empty"}, 32'(empty), 32'd1);
    check_eq({tag, "_full"}, 32'(full), 32'd0);
    check_eq({tag, "_halted"}, 32'(halted), 32'd0);
  endtask

  logic [31:0] exp_head;
  logic [31:0] next_pc;

  initial begin
    reset = 1'b1;
    squash = 1'b0;
    dispatch_count = '0;
    set_lanes(4, 32'h0, -1);
    step();
    settle();
    check_eq("acc_in_reset", 32'(in_accepted), 32'd0);
    step();
    reset = 1'b0;
    set_lanes(0, 32'h0, -1);
    settle();
    check_reset_state("reset");
    check_eq("reset_acc", 32'(in_accepted), 32'd0);

    // First enqueue, then fill to full
    set_lanes(4, 32'h0, -1);
    settle();
    check_eq("enq4_acc", 32'(in_accepted), 32'd4);
    step();
    set_lanes(0, 32'h0, -1);
    settle();
    check_eq("enq4_valid", 32'(out_valid), 32'hF);
    for (int j = 0; j < N; j++) check_eq($sformatf("enq4_pc%0d", j), out_pc[j*32 +: 32], 32'(4 * j));
    check_eq("enq4_npc0", out_npc[31:0], 32'd4);
    check_eq("enq4_free", 32'(free_slots), 32'd12);
    for (int c = 1; c < 4; c++) begin
      set_lanes(4, 32'(16 * c), -1);
      step();
    end
    set_lanes(4, 32'h40, -1);
    settle();
    check_eq("full_flag", 32'(full), 32'd1);
    check_eq("full_free", 32'(free_slots), 32'd0);
    check_eq("full_acc", 32'(in_accepted), 32'd0);
    dispatch_count = 3'd2;
    settle();
    check_eq("full_disp_acc", 32'(in_accepted), 32'd0);
    step();
    dispatch_count = 3'd0;
    settle();
    check_eq("after_disp_free", 32'(free_slots), 32'd2);
    check_eq("after_disp_acc", 32'(in_accepted), 32'd2);
    check_eq("after_disp_pc0", out_pc[31:0], 32'd8);
    step();
    set_lanes(0, 32'h0, -1);
    settle();
    check_eq("refull", 32'(full), 32'd1);

    // Squash from full, with an offered enqueue
    squash = 1'b1;
    set_lanes(4, 32'h80, -1);
    settle();
    check_eq("squash_acc", 32'(in_accepted), 32'd0);
    step();
    squash = 1'b0;
    set_lanes(0, 32'h0, -1);
    settle();
    check_eq("squash_empty", 32'(empty), 32'd1);
    check_eq("squash_free", 32'(free_slots), 32'd16);

    // Wrap-around: steady 3-in / 3-out with 4 resident entries
    set_lanes(4, 32'h100, -1);
    step();
    exp_head = 32'h100;
    next_pc = 32'h110;
    dispatch_count = 3'd3;
    for (int c = 0; c < 10; c++) begin
      set_lanes(3, next_pc, -1);
      settle();
      check_eq($sformatf("wrap_acc%0d", c), 32'(in_accepted), 32'd3);
      check_eq($sformatf("wrap_valid%0d", c), 32'(out_valid), 32'hF);
      for (int j = 0; j < N; j++)
        check_eq($sformatf("wrap_c%0d_pc%0d", c, j), out_pc[j*32 +: 32], exp_head + 32'(4 * j));
      step();
      exp_head = exp_head + 32'd12;
      next_pc = next_pc + 32'd12;
    end
    set_lanes(0, 32'h0, -1);
    dispatch_count = 3'd4;
    step();
    dispatch_count = 3'd0;
    settle();
    check_eq("wrap_drained", 32'(empty), 32'd1);

    // Halt on lane 1
    set_lanes(4, 32'h200, 1);
    settle();
    check_eq("halt_acc", 32'(in_accepted), 32'd2);
    step();
    set_lanes(4, 32'h300, -1);
    settle();
    check_eq("halt_set", 32'(halted), 32'd1);
    check_eq("halt_valid", 32'(out_valid), 32'h3);
    check_eq("halt_inst1", out_inst[63:32], HALT);
    check_eq("halted_acc", 32'(in_accepted), 32'd0);
    dispatch_count = 3'd4;
    step();
    dispatch_count = 3'd0;
    settle();
    check_eq("halt_drain_empty", 32'(empty), 32'd1);
    check_eq("halt_stays", 32'(halted), 32'd1);
    squash = 1'b1;
    step();
    squash = 1'b0;
    set_lanes(0, 32'h0, -1);
    settle();
    check_eq("halt_cleared", 32'(halted), 32'd0);

    // Squash with 9 entries, enqueue and dispatch pending
    set_lanes(4, 32'h400, -1);
    step();
    set_lanes(4, 32'h410, -1);
    step();
    set_lanes(1, 32'h420, -1);
    step();
    set_lanes(0, 32'h0, -1);
    settle();
    check_eq("nine_free", 32'(free_slots), 32'd7);
    squash = 1'b1;
    dispatch_count = 3'd2;
    set_lanes(4, 32'h500, -1);
    step();
    squash = 1'b0;
    dispatch_count = 3'd0;
    set_lanes(0, 32'h0, -1);
    settle();
    check_eq("sq9_empty", 32'(empty), 32'd1);
    check_eq("sq9_valid", 32'(out_valid), 32'h0);
    check_eq("sq9_free", 32'(free_slots), 32'd16);

    // Over-dispatch is clamped to occupancy
    set_lanes(1, 32'h600, -1);
    step();
    set_lanes(0, 32'h0, -1);
    settle();
    check_eq("one_valid", 32'(out_valid), 32'h1);
    check_eq("one_pc", out_pc[31:0], 32'h600);
    dispatch_count = 3'd4;
    step();
    dispatch_count = 3'd0;
    settle();
    check_eq("clamp_empty", 32'(empty), 32'd1);
    check_eq("clamp_free", 32'(free_slots), 32'd16);

    // Reset beats squash and enqueue, and clears a set halt latch
    set_lanes(4, 32'h700, 3);
    step();
    set_lanes(0, 32'h0, -1);
    settle();
    check_eq("pre_rst_halted", 32'(halted), 32'd1);
    reset = 1'b1;
    squash = 1'b1;
    set_lanes(4, 32'h800, -1);
    settle();
    check_eq("rst_sq_acc", 32'(in_accepted), 32'd0);
    step();
    reset = 1'b0;
    squash = 1'b0;
    set_lanes(0, 32'h0, -1);
    settle();
    check_reset_state("rst_sq");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
- N-wide in-order circular queue between fetch and the N-wide decoder.
- Absorbs fetch/dispatch rate mismatch: accepts up to N fetched instructions per cycle and presents up to N oldest entries to decode.
- Supports full flush on branch mispredict (squash).
- Latches a halt condition when a WFI instruction is enqueued.

Parameters:
- N, `N (4): superscalar width; enqueue and dequeue lanes per cycle.
- DEPTH, 16: entries; power of two, DEPTH >= N.
- HALT_INST, 32'h10500073: encoding that sets the halt latch.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- squash  in  1  flush all entries; highest priority after reset
- in_count  in  $clog2(N+1)  fetched lanes valid, packed from lane 0
- in_pc  in  N x 32  PC per lane
- in_npc  in  N x 32  NPC per lane
- in_inst  in  N x 32  instruction word per lane
- in_accepted  out  $clog2(N+1)  lanes taken this cycle (combinational)
- out_valid  out  N  lanes 0..k-1 valid, k = min(count, N)
- out_pc / out_npc / out_inst  out  N x 32  oldest entries; lane 0 is oldest
- dispatch_count  in  $clog2(N+1)  lanes consumed by decode this cycle
- free_slots  out  $clog2(DEPTH+1)  DEPTH - count (registered)
- halted  out  1  halt latch
- empty / full  out  1  count==0 / count==DEPTH

Behaviour:
- Clock and reset: single clock domain; reset is synchronous, active-high.
- State: head, tail (log2 DEPTH bits each, natural wrap), count (0..DEPTH), halted, entry storage.
- Reset: head=tail=count=0, halted=0.
  - Outputs after reset: out_valid=0, free_slots=DEPTH, empty=1, full=0, in_accepted=0.
  - Entry contents are don't-care.
- Accept calculation: in_accepted = min(in_count, free_slots, lanes up to and including the first HALT_INST lane).
  - in_accepted = 0 when halted=1, squash=1, or reset=1.
  - Only start-of-cycle free_slots is used. Space freed by same-cycle dequeue is not visible until the next cycle.
- Enqueue: accepted lane i is written to entry tail+i mod DEPTH; tail advances by in_accepted.
- Halt:
  - If an accepted lane holds HALT_INST, halted=1 next cycle.
  - Lanes after the halt lane in the same cycle are dropped.
  - halted clears only on squash or reset.
  - Entries already queued, including the halt entry, still drain.
- Dequeue:
  - eff = min(dispatch_count, k); requests beyond k are clamped and are not an error.
  - head advances by eff.
  - count_next = count + in_accepted - eff.
- Outputs:
  - out_* lane j = entry head+j mod DEPTH.
  - Outputs are driven from registered state only; there is no fetch->decode bypass.
  - Minimum enqueue-to-out_valid latency is 1 cycle.
- Squash:
  - Next cycle: head=tail=count=0, halted=0.
  - Same-cycle enqueue and dequeue are ignored.
- Priority: reset > squash > normal operation.
- Simultaneous full and dispatch: with count=DEPTH and dispatch_count=N, in_accepted=0 this cycle; the next cycle accepts up to N.
- Wrap-around: entries spanning DEPTH-1 -> 0 present in order with no bubble.
- free_slots, empty, and full reflect registered count.

Test Plan:
- Reset, then enqueue in_count=4 with PCs 0,4,8,12 -> in_accepted=4. Next cycle: out_valid=4'b1111, out_pc lanes 0..3 = 0,4,8,12, free_slots=12.
- Fill with in_count=4 for 4 cycles and dispatch_count=0 -> full=1, free_slots=0. Fifth cycle: in_accepted=0. Then dispatch_count=2 with in_count=4 -> in_accepted=0 that cycle, 2 the next.
- Wrap-around: dispatch 3 and enqueue 3 repeatedly for 10 cycles with PCs incrementing by 4 -> out_pc stays monotonic across the index-15 -> 0 boundary with no gaps.
- Halt: in_count=4 with lane 1 = 32'h10500073 -> in_accepted=2, halted=1 next cycle. Further in_count=4 -> in_accepted=0. Drain to empty -> halted stays 1. Squash -> halted=0.
- Squash mid-operation with count=9, in_count=4, dispatch_count=2 -> next cycle count=0, empty=1, out_valid=0, free_slots=16.
- dispatch_count=4 with count=1 -> only 1 dequeued, empty=1 next cycle. Reset asserted together with squash and enqueue -> reset values.
